apb_slave_mem: RTL

//  APB completer at the bridge's downstream end: consumes the sel/enable/write/strobe/addr/wdata

---
 rtl/apb_arch_pkg.sv | 19 +
 rtl/apb_wstrb_ram.sv | 38 +++
 rtl/apb_slave_mem.sv | 106 ++++++++++
 3 files changed

// File: rtl/apb_arch_pkg.sv
// Shared APB definitions: slave state encoding, default bus widths and the
// byte-lane count helper.
package apb_arch_pkg;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } apb_slv_state_t;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    function automatic int unsigned strb_w(input int unsigned dw);
        return dw / 8;
    endfunction

    localparam int unsigned STRB_W = strb_w(APB_DATA_W);

endpackage

// File: rtl/apb_wstrb_ram.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables, asynchronous read
// and asynchronous clear.
module apb_wstrb_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned IDX_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_in_range;

    assign w_in_range = 32'(i_idx) < DEPTH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_in_range) begin
            for (int unsigned l = 0; l < DATA_WIDTH / 8; l++) begin
                if (i_strb[l]) begin
                    r_mem[i_idx][8*l +: 8] <= i_wdata[8*l +: 8];
                end
            end
        end
    end

    assign o_rdata = w_in_range ? r_mem[i_idx] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-strobed word array, with a fixed number of
// wait states inserted before ready in every access phase.
module apb_slave_mem
    import apb_arch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH  = APB_DATA_W,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    enable,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] strobe,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    slverr
);

    localparam int unsigned LANES = strb_w(DATA_WIDTH);
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
    localparam int unsigned IDX_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

    apb_slv_state_t          r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [LANES-1:0]        r_strb;

    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_misalign;
    logic                    w_oob;
    logic                    w_err;
    logic                    w_ready;
    logic                    w_we;
    logic [DATA_WIDTH-1:0]   w_rd;

    // Out-of-range indices alias into the array once truncated, so the error
    // flag must gate both the write enable and the read data.
    assign w_idx      = r_addr >> OFF_W;
    assign w_misalign = (r_addr & ADDR_WIDTH'(LANES - 1)) != '0;
    assign w_oob      = 32'(w_idx) >= DEPTH;
    assign w_err      = w_misalign | w_oob;
    assign w_ready    = (r_state == S_ACCESS) && (r_cnt == '0);
    assign w_we       = w_ready & sel & enable & r_write & ~w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sel && !enable) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= CNT_W'(WAIT_STATES);
                        r_addr  <= addr;
                        r_write <= write;
                        r_wdata <= wdata;
                        r_strb  <= strobe;
                    end
                end
                S_ACCESS: begin
                    if (!sel) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (enable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    apb_wstrb_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_strb  (r_strb),
        .i_idx   (IDX_W'(w_idx)),
        .i_wdata (r_wdata),
        .o_rdata (w_rd)
    );

    assign ready  = w_ready;
    assign slverr = w_ready & w_err;
    assign rdata  = (w_ready & ~r_write & ~w_err) ? w_rd : '0;

endmodule
